// File: rtl/gray_counter.sv
// Registered Gray-code counter: binary count and its Gray encoding held in lock-step
// flip-flops, with up/down stepping, wrap or saturate, and binary/Gray synchronous load.
module gray_counter #(
    parameter int unsigned WIDTH     = 10,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             up,
    input  logic             sload,
    input  logic             sload_gray,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] LP_RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] LP_RST_GRAY = LP_RST_BIN ^ (LP_RST_BIN >> 1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_load_g2b;
    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_step_bin;
    logic             w_next_wrap;
    logic             w_at_end;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_load_g2b = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_load_g2b[i] = ^(load_data >> i);
        end
    end

    assign w_at_end   = up ? (&r_bin) : ~(|r_bin);
    assign w_step_bin = up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));

    always_comb begin
        w_next_bin  = r_bin;
        w_next_wrap = 1'b0;
        if (sload) begin
            w_next_bin = sload_gray ? w_load_g2b : load_data;
        end else if (ena) begin
            if (w_at_end) begin
                if (!SATURATE) begin
                    w_next_bin  = w_step_bin;
                    w_next_wrap = 1'b1;
                end
            end else begin
                w_next_bin = w_step_bin;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= LP_RST_BIN;
            r_gray <= LP_RST_GRAY;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_bin ^ (w_next_bin >> 1);
            r_wrap <= w_next_wrap;
        end
    end

    assign bin  = r_bin;
    assign gray = r_gray;
    assign wrap = r_wrap;
    assign tc   = w_at_end;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: wrapping, saturating and non-zero-reset instances
// share one set of inputs; each scenario checks the instance it targets.
module tb_gray_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       up = 1'b0;
    logic       sload = 1'b0;
    logic       sload_gray = 1'b0;
    logic [9:0] load_data = '0;

    logic [9:0] a_bin, a_gray, b_bin, b_gray, c_bin, c_gray;
    logic       a_tc, a_wrap, b_tc, b_wrap, c_tc, c_wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(10), .SATURATE(1'b0), .RESET_VAL(0)) u_a (
        .clk(clk), .rst(rst), .ena(ena), .up(up), .sload(sload), .sload_gray(sload_gray),
        .load_data(load_data), .bin(a_bin), .gray(a_gray), .tc(a_tc), .wrap(a_wrap));
    gray_counter #(.WIDTH(10), .SATURATE(1'b1), .RESET_VAL(0)) u_b (
        .clk(clk), .rst(rst), .ena(ena), .up(up), .sload(sload), .sload_gray(sload_gray),
        .load_data(load_data), .bin(b_bin), .gray(b_gray), .tc(b_tc), .wrap(b_wrap));
    gray_counter #(.WIDTH(10), .SATURATE(1'b0), .RESET_VAL(5)) u_c (
        .clk(clk), .rst(rst), .ena(ena), .up(up), .sload(sload), .sload_gray(sload_gray),
        .load_data(load_data), .bin(c_bin), .gray(c_gray), .tc(c_tc), .wrap(c_wrap));

    typedef struct {
        logic       sload;
        logic       sload_gray;
        logic       ena;
        logic       up;
        logic [9:0] data;
        logic [9:0] e_bin;
        logic [9:0] e_gray;
        logic       e_wrap;
        logic       e_tc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] g2b(input logic [9:0] g);
        logic [9:0] b;
        b[9] = g[9];
        for (int i = 8; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic drive(input logic s, input logic sg, input logic e, input logic u,
                         input logic [9:0] d);
        sload = s; sload_gray = sg; ena = e; up = u; load_data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [9:0] model;
        logic [9:0] prev_gray;
        logic [9:0] diff;
        int         wrap_cnt;

        //            sld sg  ena up  data    bin     gray    wrap tc
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 10'h3FF, 10'h200, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 10'h3FE, 10'h201, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'h3FF, 10'h2AA, 10'h3FF, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'h005, 10'h005, 10'h007, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 10'h005, 10'h007, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 10'h006, 10'h005, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 10'h3FE, 10'h3FE, 10'h201, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 10'h3FF, 10'h200, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 10'h000, 10'h000, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 10'h000, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h001, 10'h001, 10'h001, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'h200, 10'h3FF, 10'h200, 1'b0, 1'b0};

        // Reset state, held in reset across an edge
        #12;
        chk("rst_a_bin", 32'(a_bin), 32'h000);
        chk("rst_a_gray", 32'(a_gray), 32'h000);
        chk("rst_a_wrap", 32'(a_wrap), 32'h0);
        chk("rst_a_tc", 32'(a_tc), 32'h1);
        chk("rst_c_bin", 32'(c_bin), 32'h005);
        chk("rst_c_gray", 32'(c_gray), 32'h007);
        rst = 1'b0;
        #1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].sload, vecs[i].sload_gray, vecs[i].ena, vecs[i].up, vecs[i].data);
            tick();
            chk($sformatf("vec%0d_bin", i), 32'(a_bin), 32'(vecs[i].e_bin));
            chk($sformatf("vec%0d_gray", i), 32'(a_gray), 32'(vecs[i].e_gray));
            chk($sformatf("vec%0d_wrap", i), 32'(a_wrap), 32'(vecs[i].e_wrap));
            chk($sformatf("vec%0d_tc", i), 32'(a_tc), 32'(vecs[i].e_tc));
        end

        // Hold: A sits at 0x3FF / 0x200
        drive(1'b0, 1'b0, 1'b0, 1'b1, 10'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_bin", 32'(a_bin), 32'h3FF);
            chk("hold_gray", 32'(a_gray), 32'h200);
            chk("hold_wrap", 32'(a_wrap), 32'h0);
        end

        // Full up sweep from reset
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model = '0;
        prev_gray = '0;
        wrap_cnt = 0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 10'h0);
        for (int i = 0; i < 1024; i++) begin
            tick();
            model = model + 10'd1;
            diff = a_gray ^ prev_gray;
            prev_gray = a_gray;
            if (a_wrap) wrap_cnt++;
            chk("sweep_bin", 32'(a_bin), 32'(model));
            chk("sweep_g2b", 32'(g2b(a_gray)), 32'(model));
            chk("sweep_onebit", 32'($countones(diff)), 32'd1);
            chk("sweep_wrap", 32'(a_wrap), 32'(model == 10'h000));
            chk("sweep_tc", 32'(a_tc), 32'(model == 10'h3FF));
        end
        chk("sweep_wrap_count", 32'(wrap_cnt), 32'd1);

        // Saturation on instance B
        drive(1'b1, 1'b0, 1'b0, 1'b1, 10'h3FF);
        tick();
        chk("sat_load_bin", 32'(b_bin), 32'h3FF);
        chk("sat_load_tc", 32'(b_tc), 32'h1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 10'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat_bin", 32'(b_bin), 32'h3FF);
            chk("sat_gray", 32'(b_gray), 32'h200);
            chk("sat_wrap", 32'(b_wrap), 32'h0);
            chk("sat_tc", 32'(b_tc), 32'h1);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'h0);
        tick();
        chk("sat_down_bin", 32'(b_bin), 32'h3FE);
        chk("sat_down_gray", 32'(b_gray), 32'h201);

        // Reset between edges clears a pending wrap pulse
        drive(1'b1, 1'b0, 1'b0, 1'b1, 10'h3FF);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 10'h0);
        tick();
        chk("pend_wrap_a", 32'(a_wrap), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_clr_wrap_a", 32'(a_wrap), 32'h0);
        chk("rst_clr_wrap_c", 32'(c_wrap), 32'h0);
        chk("rst_clr_bin_c", 32'(c_bin), 32'h005);
        #1;
        rst = 1'b0;

        // Async reset mid-count on instance C (RESET_VAL=5)
        drive(1'b1, 1'b0, 1'b0, 1'b1, 10'h122);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 10'h0);
        tick();
        chk("c_count_bin", 32'(c_bin), 32'h123);
        rst = 1'b1;
        #1;
        chk("c_async_bin", 32'(c_bin), 32'h005);
        chk("c_async_gray", 32'(c_gray), 32'h007);
        chk("c_async_wrap", 32'(c_wrap), 32'h0);
        #1;
        rst = 1'b0;
        tick();
        chk("c_release_bin", 32'(c_bin), 32'h006);
        chk("c_release_gray", 32'(c_gray), 32'h005);
        chk("c_release_wrap", 32'(c_wrap), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised registered Gray-code counter that keeps a binary count and its Gray encoding in lock-step. It supports up/down stepping, wrap or saturate at the ends, and synchronous load from either a binary or a Gray-coded source. It is the sequential successor to the combinational binary/Gray converters. It sits at the source end of multi-bit counters that are later sampled by other logic, such as FIFO pointers and position encoders, where the Gray value must change by exactly one bit per step.

## Interface

Parameters:
- WIDTH, 10, counter width in bits; must be 2 or more.
- SATURATE, 0. 0 means wrap modulo 2^WIDTH; 1 means hold at the end value instead of wrapping.
- RESET_VAL, 0, binary reset value; must be less than 2^WIDTH.

Ports (one clock; reset is asynchronous and active-high):
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- ena, input, 1, count enable; takes one step per clock while high.
- up, input, 1, direction; 1 increments, 0 decrements. Sampled only with ena.
- sload, input, 1, synchronous load strobe.
- sload_gray, input, 1, load encoding; 1 means load_data is Gray, 0 means binary.
- load_data, input, WIDTH, load value.
- bin, output, WIDTH, registered binary count.
- gray, output, WIDTH, registered Gray count; always equals bin ^ (bin >> 1).
- tc, output, 1, terminal count; combinational from the registered count and the current up.
- wrap, output, 1, registered one-cycle pulse marking a wrap.

## Operation

- **Priority at each rising clk edge:**
  - sload first: if sload is high, load.
  - Otherwise, if ena is high, step.
  - Otherwise, hold.
- **Load:**
  - sload_gray=0: next_bin = load_data.
  - sload_gray=1: next_bin is the prefix-XOR Gray-to-binary conversion of load_data. The MSB passes through; bit i = load_data[i] ^ next_bin[i+1].
  - next_gray = next_bin ^ (next_bin >> 1).
  - A load never asserts wrap. ena and up are ignored in the load cycle.
- **Step, up=1:** next_bin = bin + 1, computed in WIDTH bits.
- **Step, up=0:** next_bin = bin - 1, computed in WIDTH bits.
- **Step at the end values:**
  - The end values are all-ones when counting up and zero when counting down.
  - SATURATE=0: the count wraps (all-ones to 0, or 0 to all-ones), and wrap is 1 in the following cycle.
  - SATURATE=1: bin and gray hold their values, and wrap stays 0.
- **tc** = (up & bin == all-ones) | (~up & bin == 0). It is valid regardless of ena and SATURATE.
- **wrap** is registered and is 1 for exactly the one cycle after the edge at which a wrapping step occurred; otherwise it is 0.
- **Invariants:**
  - gray == bin ^ (bin >> 1) in every cycle, including immediately after reset.
  - Across any step that changes the count, gray changes in exactly one bit.
  - A saturated hold changes no bits.
- Both bin and gray are held in flip-flops. The gray output is not produced by converting after the register.

## Timing

- **Reset:** rst high forces the outputs immediately, without waiting for clk:
  - bin = RESET_VAL.
  - gray = RESET_VAL ^ (RESET_VAL >> 1).
  - wrap = 0.
  - tc follows the reset count and up.
  - Holds while rst is high.
- **Release from reset:** the first edge after rst falls may load or step normally.
- **Reset mid-operation:** an in-flight load or step is discarded, and a pending wrap pulse is cleared.
- **Latency:** one clock from sampled sload or ena to updated bin and gray; wrap appears in that same updated cycle.
- **Back-to-back steps:** steps every cycle are supported. Continuous up-counting with SATURATE=0 pulses wrap once every 2^WIDTH cycles.
- **Simultaneous sload and ena:** the load wins, and no step is taken that cycle.
- **Direction change:** up may change every cycle. Only the value present at the sampling edge matters.

## Test plan

- **Full up sweep:** WIDTH=10, SATURATE=0, RESET_VAL=0, ena=1, up=1 for 1024 cycles.
  - Each step changes exactly one gray bit.
  - Every cycle, gray_to_bin(gray) == bin.
  - tc=1 at bin=0x3FF.
  - Count goes 0x3FF to 0x000, with wrap=1 for one cycle only.
- **Down wrap:** from reset 0, up=0, one ena cycle.
  - Before the step, tc=1.
  - After the step: bin=0x3FF, gray=0x200, wrap=1.
  - After a second step: bin=0x3FE, gray=0x201, wrap=0.
- **Saturate:** SATURATE=1, load binary 0x3FF, then 5 up steps.
  - bin stays 0x3FF and gray stays 0x200.
  - wrap is never asserted; tc=1 throughout.
  - One down step then gives bin=0x3FE.
- **Load encodings:**
  - sload=1, sload_gray=1, load_data=0x3FF gives bin=0x2AA and gray=0x3FF.
  - sload_gray=0, load_data=5 gives bin=5 and gray=7.
  - sload=1 with ena=1 and up=1 loads 5, not 6.
- **Hold:** ena=0 and sload=0 for 10 cycles: bin and gray are unchanged and wrap=0.
- **Async reset mid-count:** RESET_VAL=5, count to 0x123, then pulse rst between clock edges.
  - bin=5 and gray=7 before the next edge, and wrap=0.
  - The first edge after release with ena=1 and up=1 gives bin=6 and gray=5.
